// File: rtl/id_stage_pipe.sv
// Decode stage: controller, NREG x XLEN register file, RAW hazard detection and the ID/EX register.
// Optional macro ID_WB_BYPASS_EN forwards a same-cycle WB write into the operand read.

module controller (
  input  logic [5:0] opcode,
  output logic [3:0] exe_cmd,
  output logic [1:0] branch_type,
  output logic       mem_r_en,
  output logic       mem_w_en,
  output logic       wb_en,
  output logic       is_immediate,
  output logic       is_single_src,
  output logic       is_bne
);
  localparam logic [3:0] CMD_ADD = 4'd1, CMD_SUB = 4'd2, CMD_AND = 4'd3, CMD_OR  = 4'd4,
                         CMD_NOR = 4'd5, CMD_XOR = 4'd6, CMD_SLL = 4'd7, CMD_SRL = 4'd8;

  always_comb begin
    exe_cmd       = 4'd0;
    branch_type   = 2'd0;
    mem_r_en      = 1'b0;
    mem_w_en      = 1'b0;
    wb_en         = 1'b0;
    is_immediate  = 1'b0;
    is_single_src = 1'b1;
    is_bne        = 1'b0;
    case (opcode)
      6'd1:  begin exe_cmd = CMD_ADD; wb_en = 1'b1; is_single_src = 1'b0; end
      6'd3:  begin exe_cmd = CMD_SUB; wb_en = 1'b1; is_single_src = 1'b0; end
      6'd5:  begin exe_cmd = CMD_AND; wb_en = 1'b1; is_single_src = 1'b0; end
      6'd6:  begin exe_cmd = CMD_OR;  wb_en = 1'b1; is_single_src = 1'b0; end
      6'd7:  begin exe_cmd = CMD_NOR; wb_en = 1'b1; is_single_src = 1'b0; end
      6'd8:  begin exe_cmd = CMD_XOR; wb_en = 1'b1; is_single_src = 1'b0; end
      6'd9:  begin exe_cmd = CMD_SLL; wb_en = 1'b1; is_single_src = 1'b0; end
      6'd10: begin exe_cmd = CMD_SRL; wb_en = 1'b1; is_single_src = 1'b0; end
      6'd32: begin exe_cmd = CMD_ADD; wb_en = 1'b1; is_immediate = 1'b1; end
      6'd33: begin exe_cmd = CMD_SUB; wb_en = 1'b1; is_immediate = 1'b1; end
      6'd36: begin exe_cmd = CMD_ADD; mem_r_en = 1'b1; wb_en = 1'b1; is_immediate = 1'b1; end
      6'd37: begin exe_cmd = CMD_ADD; mem_w_en = 1'b1; is_immediate = 1'b1; end
      6'd40: begin branch_type = 2'd1; is_immediate = 1'b1; end
      6'd41: begin branch_type = 2'd2; is_immediate = 1'b1; is_bne = 1'b1; end
      6'd42: begin branch_type = 2'd3; is_immediate = 1'b1; end
      default: ;
    endcase
  end
endmodule

// in_valid qualifies Instruction; out_valid qualifies ID/EX contents. stall_out holds PC and IF/ID,
// freeze_in holds ID/EX; neither side ever drops a qualified instruction.
module id_stage_pipe #(
  parameter int XLEN   = 32,
  parameter int NREG   = 32,
  parameter int FWD_EN = 0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  input  logic [31:0]     Instruction,
  input  logic            freeze_in,
  input  logic            flush,
  input  logic            WB_Write_Enable,
  input  logic [4:0]      WB_Dest,
  input  logic [XLEN-1:0] WB_Data,
  input  logic [4:0]      EXE_Dest,
  input  logic [4:0]      MEM_Dest,
  input  logic            EXE_WB_EN,
  input  logic            MEM_WB_EN,
  input  logic            EXE_MEM_R_EN,
  output logic            stall_out,
  output logic            out_valid,
  output logic [4:0]      Dest,
  output logic [XLEN-1:0] Val1,
  output logic [XLEN-1:0] Val2,
  output logic [XLEN-1:0] Reg2,
  output logic [3:0]      EXE_CMD,
  output logic [1:0]      Branch_Type,
  output logic            MEM_R_EN,
  output logic            MEM_W_EN,
  output logic            WB_EN,
  output logic            is_single_src,
  output logic            is_BNE,
  output logic [15:0]     hazard_cnt
);
  localparam int AW = $clog2(NREG);

  logic [3:0] d_cmd;
  logic [1:0] d_br;
  logic       d_mr, d_mw, d_wb, d_imm, d_ss, d_bne;

  controller u_ctrl (
    .opcode(Instruction[31:26]), .exe_cmd(d_cmd), .branch_type(d_br), .mem_r_en(d_mr),
    .mem_w_en(d_mw), .wb_en(d_wb), .is_immediate(d_imm), .is_single_src(d_ss), .is_bne(d_bne)
  );

  logic [4:0]      src1, src2;
  logic [AW-1:0]   src1_idx, src2_idx, wb_idx;
  logic [XLEN-1:0] rf [NREG];
  logic [XLEN-1:0] rd1, rd2, imm_ext;

  assign src1     = Instruction[25:21];
  assign src2     = Instruction[20:16];
  assign src1_idx = src1[AW-1:0];
  assign src2_idx = src2[AW-1:0];
  assign wb_idx   = WB_Dest[AW-1:0];
  assign imm_ext  = XLEN'($signed(Instruction[15:0]));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREG; i++) rf[i] <= '0;
    end else if (WB_Write_Enable && WB_Dest != 5'd0) begin
      rf[wb_idx] <= WB_Data;
    end
  end

  always_comb begin
    rd1 = (src1_idx == '0) ? '0 : rf[src1_idx];
    rd2 = (src2_idx == '0) ? '0 : rf[src2_idx];
`ifdef ID_WB_BYPASS_EN
    if (WB_Write_Enable && WB_Dest != 5'd0) begin
      if (src1_idx != '0 && wb_idx == src1_idx) rd1 = WB_Data;
      if (src2_idx != '0 && wb_idx == src2_idx) rd2 = WB_Data;
    end
`endif
  end

  // Stores and BNE are single-source immediates that still read src2.
  logic uses2, exe_hit, mem_hit, hazard_raw, hazard;
  assign uses2   = !d_ss | d_mw | d_bne;
  assign exe_hit = (EXE_Dest != 5'd0) && (EXE_Dest == src1 || (uses2 && EXE_Dest == src2));
  assign mem_hit = (MEM_Dest != 5'd0) && (MEM_Dest == src1 || (uses2 && MEM_Dest == src2));
  assign hazard_raw = (FWD_EN != 0) ? (EXE_MEM_R_EN & exe_hit)
                                    : ((EXE_WB_EN & exe_hit) | (MEM_WB_EN & mem_hit));
  assign hazard    = rst & in_valid & hazard_raw;
  assign stall_out = rst & (hazard | freeze_in);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid     <= 1'b0;
      EXE_CMD       <= '0;
      Branch_Type   <= '0;
      MEM_R_EN      <= 1'b0;
      MEM_W_EN      <= 1'b0;
      WB_EN         <= 1'b0;
      is_single_src <= 1'b0;
      is_BNE        <= 1'b0;
      Dest          <= '0;
      Val1          <= '0;
      Val2          <= '0;
      Reg2          <= '0;
      hazard_cnt    <= '0;
    end else begin
      if (flush || (!freeze_in && hazard)) begin
        out_valid     <= 1'b0;
        EXE_CMD       <= '0;
        Branch_Type   <= '0;
        MEM_R_EN      <= 1'b0;
        MEM_W_EN      <= 1'b0;
        WB_EN         <= 1'b0;
        is_single_src <= 1'b0;
        is_BNE        <= 1'b0;
      end else if (!freeze_in) begin
        out_valid     <= in_valid;
        EXE_CMD       <= in_valid ? d_cmd : 4'd0;
        Branch_Type   <= in_valid ? d_br  : 2'd0;
        MEM_R_EN      <= in_valid & d_mr;
        MEM_W_EN      <= in_valid & d_mw;
        WB_EN         <= in_valid & d_wb;
        is_single_src <= in_valid & d_ss;
        is_BNE        <= in_valid & d_bne;
      end
      // Data fields are don't-care behind a bubble, so only freeze has to hold them.
      if (!freeze_in) begin
        Dest <= d_imm ? Instruction[20:16] : Instruction[15:11];
        Val1 <= rd1;
        Val2 <= d_imm ? imm_ext : rd2;
        Reg2 <= rd2;
      end
      if (!flush && !freeze_in && hazard && hazard_cnt != 16'hFFFF)
        hazard_cnt <= hazard_cnt + 16'd1;
    end
  end
endmodule

// File: tb/tb_id_stage_pipe.sv
// Randomized bench for id_stage_pipe: one FWD_EN=0 and one FWD_EN=1 instance on shared inputs,
// both checked every cycle against a table-driven reference model.
module tb_id_stage_pipe;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, in_valid, freeze_in, flush, wb_we, exe_wb_en, mem_wb_en, exe_mem_r_en;
  logic [31:0] Instruction, wb_data;
  logic [4:0]  wb_dest, exe_dest, mem_dest;

  logic        stall_o [2], ov_o [2], mr_o [2], mw_o [2], wb_o [2], ss_o [2], bne_o [2];
  logic [4:0]  dest_o [2];
  logic [31:0] val1_o [2], val2_o [2], reg2_o [2];
  logic [3:0]  cmd_o [2];
  logic [1:0]  br_o [2];
  logic [15:0] cnt_o [2];

  id_stage_pipe #(.XLEN(32), .NREG(32), .FWD_EN(0)) u_fwd0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .Instruction(Instruction), .freeze_in(freeze_in),
    .flush(flush), .WB_Write_Enable(wb_we), .WB_Dest(wb_dest), .WB_Data(wb_data),
    .EXE_Dest(exe_dest), .MEM_Dest(mem_dest), .EXE_WB_EN(exe_wb_en), .MEM_WB_EN(mem_wb_en),
    .EXE_MEM_R_EN(exe_mem_r_en), .stall_out(stall_o[0]), .out_valid(ov_o[0]), .Dest(dest_o[0]),
    .Val1(val1_o[0]), .Val2(val2_o[0]), .Reg2(reg2_o[0]), .EXE_CMD(cmd_o[0]),
    .Branch_Type(br_o[0]), .MEM_R_EN(mr_o[0]), .MEM_W_EN(mw_o[0]), .WB_EN(wb_o[0]),
    .is_single_src(ss_o[0]), .is_BNE(bne_o[0]), .hazard_cnt(cnt_o[0])
  );

  id_stage_pipe #(.XLEN(32), .NREG(32), .FWD_EN(1)) u_fwd1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .Instruction(Instruction), .freeze_in(freeze_in),
    .flush(flush), .WB_Write_Enable(wb_we), .WB_Dest(wb_dest), .WB_Data(wb_data),
    .EXE_Dest(exe_dest), .MEM_Dest(mem_dest), .EXE_WB_EN(exe_wb_en), .MEM_WB_EN(mem_wb_en),
    .EXE_MEM_R_EN(exe_mem_r_en), .stall_out(stall_o[1]), .out_valid(ov_o[1]), .Dest(dest_o[1]),
    .Val1(val1_o[1]), .Val2(val2_o[1]), .Reg2(reg2_o[1]), .EXE_CMD(cmd_o[1]),
    .Branch_Type(br_o[1]), .MEM_R_EN(mr_o[1]), .MEM_W_EN(mw_o[1]), .WB_EN(wb_o[1]),
    .is_single_src(ss_o[1]), .is_BNE(bne_o[1]), .hazard_cnt(cnt_o[1])
  );

  // Reference decode table: the instruction set as documented, one row per opcode.
  typedef struct packed {
    logic [3:0] cmd;
    logic [1:0] br;
    logic mr, mw, wb, imm, ss, bne;
  } dec_t;

  typedef struct {
    logic        v;
    logic [4:0]  dest;
    logic [31:0] v1, v2, r2;
    dec_t        c;
    logic [15:0] cnt;
  } exp_t;

  dec_t        dec_tab [64];
  exp_t        ex [2];
  logic [31:0] mrf [32];
  int          n_tests = 0;
  int          n_fail  = 0;

  function automatic dec_t mk(input logic [3:0] cmd, input logic [1:0] br, input logic mr,
                              input logic mw, input logic wb, input logic imm, input logic ss,
                              input logic bne);
    return {cmd, br, mr, mw, wb, imm, ss, bne};
  endfunction

  task automatic init_table();
    for (int i = 0; i < 64; i++) dec_tab[i] = mk(4'd0, 2'd0, 0, 0, 0, 0, 1, 0);
    dec_tab[1]  = mk(4'd1, 2'd0, 0, 0, 1, 0, 0, 0);
    dec_tab[3]  = mk(4'd2, 2'd0, 0, 0, 1, 0, 0, 0);
    dec_tab[5]  = mk(4'd3, 2'd0, 0, 0, 1, 0, 0, 0);
    dec_tab[6]  = mk(4'd4, 2'd0, 0, 0, 1, 0, 0, 0);
    dec_tab[7]  = mk(4'd5, 2'd0, 0, 0, 1, 0, 0, 0);
    dec_tab[8]  = mk(4'd6, 2'd0, 0, 0, 1, 0, 0, 0);
    dec_tab[9]  = mk(4'd7, 2'd0, 0, 0, 1, 0, 0, 0);
    dec_tab[10] = mk(4'd8, 2'd0, 0, 0, 1, 0, 0, 0);
    dec_tab[32] = mk(4'd1, 2'd0, 0, 0, 1, 1, 1, 0);
    dec_tab[33] = mk(4'd2, 2'd0, 0, 0, 1, 1, 1, 0);
    dec_tab[36] = mk(4'd1, 2'd0, 1, 0, 1, 1, 1, 0);
    dec_tab[37] = mk(4'd1, 2'd0, 0, 1, 0, 1, 1, 0);
    dec_tab[40] = mk(4'd0, 2'd1, 0, 0, 0, 1, 1, 0);
    dec_tab[41] = mk(4'd0, 2'd2, 0, 0, 0, 1, 1, 1);
    dec_tab[42] = mk(4'd0, 2'd3, 0, 0, 0, 1, 1, 0);
  endtask

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] rf_read(input logic [4:0] idx);
    if (idx == 5'd0) return 32'd0;
`ifdef ID_WB_BYPASS_EN
    if (wb_we && wb_dest == idx) return wb_data;
`endif
    return mrf[idx];
  endfunction

  // A hazard exists when some still-pending writer targets a register this instruction reads.
  function automatic bit model_hazard(input int fwd, input dec_t d);
    logic [4:0] writers [$];
    logic [4:0] reads [$];
    if (!in_valid) return 0;
    if (fwd == 1) begin
      if (exe_mem_r_en) writers.push_back(exe_dest);
    end else begin
      if (exe_wb_en) writers.push_back(exe_dest);
      if (mem_wb_en) writers.push_back(mem_dest);
    end
    reads.push_back(Instruction[25:21]);
    if (!d.ss || d.mw || d.bne) reads.push_back(Instruction[20:16]);
    foreach (writers[w])
      foreach (reads[r])
        if (writers[w] != 5'd0 && writers[w] == reads[r]) return 1;
    return 0;
  endfunction

  task automatic check_outputs();
    for (int i = 0; i < 2; i++) begin
      check_eq($sformatf("u%0d.out_valid", i), ov_o[i], ex[i].v);
      check_eq($sformatf("u%0d.ctrl", i),
               {cmd_o[i], br_o[i], mr_o[i], mw_o[i], wb_o[i], ss_o[i], bne_o[i]},
               {ex[i].c.cmd, ex[i].c.br, ex[i].c.mr, ex[i].c.mw, ex[i].c.wb, ex[i].c.ss, ex[i].c.bne});
      check_eq($sformatf("u%0d.hazard_cnt", i), cnt_o[i], ex[i].cnt);
      if (ex[i].v) begin
        check_eq($sformatf("u%0d.dest", i), dest_o[i], ex[i].dest);
        check_eq($sformatf("u%0d.val1", i), val1_o[i], ex[i].v1);
        check_eq($sformatf("u%0d.val2", i), val2_o[i], ex[i].v2);
        check_eq($sformatf("u%0d.reg2", i), reg2_o[i], ex[i].r2);
      end
    end
  endtask

  // Called right after a falling edge with inputs already driven; returns at the next falling edge.
  task automatic step();
    dec_t d;
    bit   hz;
    #1;
    d = dec_tab[Instruction[31:26]];
    for (int i = 0; i < 2; i++) begin
      hz = model_hazard(i, d);
      check_eq($sformatf("u%0d.stall_out", i), stall_o[i], hz | freeze_in);
      if (flush) begin
        ex[i].v = 0;
        ex[i].c = '0;
      end else if (freeze_in) begin
        ex[i].v = ex[i].v;
      end else if (hz) begin
        ex[i].v = 0;
        ex[i].c = '0;
        if (ex[i].cnt != 16'hFFFF) ex[i].cnt = ex[i].cnt + 16'd1;
      end else begin
        ex[i].v    = in_valid;
        ex[i].c    = in_valid ? d : dec_t'(0);
        ex[i].dest = d.imm ? Instruction[20:16] : Instruction[15:11];
        ex[i].v1   = rf_read(Instruction[25:21]);
        ex[i].r2   = rf_read(Instruction[20:16]);
        ex[i].v2   = d.imm ? {{16{Instruction[15]}}, Instruction[15:0]} : ex[i].r2;
      end
    end
    @(posedge clk);
    if (wb_we && wb_dest != 5'd0) mrf[wb_dest] = wb_data;
    @(negedge clk);
    check_outputs();
  endtask

  task automatic set_idle();
    in_valid = 0; Instruction = '0; freeze_in = 0; flush = 0; wb_we = 0; wb_dest = '0;
    wb_data = '0; exe_dest = '0; mem_dest = '0; exe_wb_en = 0; mem_wb_en = 0; exe_mem_r_en = 0;
  endtask

  // Asserts reset asynchronously between edges; the outputs must clear without a clock.
  task automatic apply_reset();
    rst = 0;
    #1;
    for (int r = 0; r < 32; r++) mrf[r] = '0;
    for (int i = 0; i < 2; i++) begin
      ex[i] = '{v: 0, dest: '0, v1: '0, v2: '0, r2: '0, c: '0, cnt: '0};
      check_eq($sformatf("u%0d.rst_stall", i), stall_o[i], 1'b0);
      check_eq($sformatf("u%0d.rst_data", i), {dest_o[i], val1_o[i], val2_o[i][26:0]}, 64'd0);
      check_eq($sformatf("u%0d.rst_reg2", i), reg2_o[i], 32'd0);
    end
    check_outputs();
    @(posedge clk);
    @(negedge clk);
    rst = 1;
  endtask

  logic [31:0] rnd;
  logic [31:0] exp9;
  logic [5:0]  ops [17] = '{6'd0, 6'd1, 6'd3, 6'd5, 6'd6, 6'd7, 6'd8, 6'd9, 6'd10, 6'd32,
                            6'd33, 6'd36, 6'd37, 6'd40, 6'd41, 6'd42, 6'd2};

  initial begin
    init_table();
    set_idle();
    rst = 0;
    @(negedge clk);
    apply_reset();

    // Write r3, then read it back one cycle later.
    set_idle(); in_valid = 1; wb_we = 1; wb_dest = 5'd3; wb_data = 32'h0000_00A5;
    step();
    set_idle(); in_valid = 1; Instruction = {6'd1, 5'd3, 5'd0, 5'd7, 11'd0};
    step();
    check_eq("r3_read", val1_o[0], 32'h0000_00A5);

    // Same-cycle write and read of r9.
    set_idle(); in_valid = 1; Instruction = {6'd1, 5'd9, 5'd3, 5'd8, 11'd0};
    wb_we = 1; wb_dest = 5'd9; wb_data = 32'h0000_005A;
`ifdef ID_WB_BYPASS_EN
    exp9 = 32'h0000_005A;
`else
    exp9 = 32'h0;
`endif
    step();
    check_eq("same_cycle_read", val1_o[0], exp9);

    // Negative immediate.
    set_idle(); in_valid = 1; Instruction = {6'd32, 5'd1, 5'd6, 16'hFFF0};
    step();
    check_eq("imm_val2", val2_o[0], 32'hFFFF_FFF0);
    check_eq("imm_dest", dest_o[0], 5'd6);

    // EXE write-back hazard on src2 of a two-source op.
    set_idle(); in_valid = 1; exe_wb_en = 1; exe_dest = 5'd4;
    Instruction = {6'd1, 5'd2, 5'd4, 5'd7, 11'd0};
    step();
    check_eq("haz_bubble_fwd0", {ov_o[0], wb_o[0]}, 2'b00);
    check_eq("haz_pass_fwd1", ov_o[1], 1'b1);
    check_eq("haz_cnt_fwd0", cnt_o[0], 16'd1);
    exe_dest = 5'd0;
    step();
    check_eq("no_haz_r0", ov_o[0], 1'b1);
    exe_dest = 5'd4; exe_mem_r_en = 1;
    step();
    check_eq("load_use_fwd1", ov_o[1], 1'b0);
    check_eq("load_use_cnt", {cnt_o[0], cnt_o[1]}, {16'd2, 16'd1});

    // Flush + freeze + hazard together: bubble without counting.
    flush = 1; freeze_in = 1;
    step();
    check_eq("prio_cnt", {cnt_o[0], cnt_o[1]}, {16'd2, 16'd1});
    check_eq("prio_valid", ov_o[0], 1'b0);
    flush = 0;
    step();
    freeze_in = 0;

    for (int n = 0; n < 600; n++) begin
      rnd          = $urandom();
      in_valid     = ($urandom_range(0, 9) != 0);
      Instruction  = {ops[$urandom_range(0, 16)], 5'($urandom_range(0, 7)),
                      5'($urandom_range(0, 7)), rnd[15:0]};
      freeze_in    = ($urandom_range(0, 9) == 0);
      flush        = ($urandom_range(0, 11) == 0);
      wb_we        = ($urandom_range(0, 1) == 1);
      wb_dest      = 5'($urandom_range(0, 7));
      wb_data      = $urandom();
      exe_dest     = 5'($urandom_range(0, 7));
      mem_dest     = 5'($urandom_range(0, 7));
      exe_wb_en    = ($urandom_range(0, 2) == 0);
      mem_wb_en    = ($urandom_range(0, 2) == 0);
      exe_mem_r_en = ($urandom_range(0, 3) == 0);
      step();
    end

    // Reset while stalled, then r5 must read as zero.
    set_idle(); in_valid = 1; exe_wb_en = 1; exe_mem_r_en = 1; exe_dest = 5'd5;
    Instruction = {6'd1, 5'd5, 5'd5, 5'd7, 11'd0};
    wb_we = 1; wb_dest = 5'd5; wb_data = 32'hDEAD_BEEF;
    step();
    apply_reset();
    set_idle(); in_valid = 1; Instruction = {6'd1, 5'd5, 5'd5, 5'd7, 11'd0};
    step();
    check_eq("r5_after_reset", {val1_o[0], reg2_o[0]}, 64'd0);

    // Saturation of the bubble counter.
    set_idle(); in_valid = 1; exe_wb_en = 1; exe_mem_r_en = 1; exe_dest = 5'd2;
    Instruction = {6'd1, 5'd2, 5'd0, 5'd7, 11'd0};
    for (int n = 0; n < 32'h10004; n++) step();
    check_eq("sat_cnt0", cnt_o[0], 16'hFFFF);
    check_eq("sat_cnt1", cnt_o[1], 16'hFFFF);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
